// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared sizing constants and slot prefix-count helper for the free list
package free_list_pkg;

  localparam int FL_PR_NUM = 64;
  localparam int FL_AR_NUM = 32;
  localparam int FL_PR_W   = 6;
  localparam int FL_IDX_W  = 5;
  localparam int FL_PTR_W  = 6;
  localparam int FL_SLOTS  = 4;

  // Number of enabled slots strictly below slot n; n == FL_SLOTS gives the popcount.
  function automatic logic [2:0] prefix_cnt(input logic [3:0] en, input int n);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < FL_SLOTS; i++) begin
      if (i < n && en[i]) c = c + 3'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/free_list_compact.sv
// rtl/free_list_compact.sv - 4-slot prefix offsets and popcount for compacted alloc/free
module free_list_compact
  import free_list_pkg::*;
(
  input  logic [3:0] en,
  output logic [2:0] off0,
  output logic [2:0] off1,
  output logic [2:0] off2,
  output logic [2:0] off3,
  output logic [2:0] cnt
);

  assign off0 = prefix_cnt(en, 0);
  assign off1 = prefix_cnt(en, 1);
  assign off2 = prefix_cnt(en, 2);
  assign off3 = prefix_cnt(en, 3);
  assign cnt  = prefix_cnt(en, 4);

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - 4-wide physical register free list with commit-point flush recovery
// Optional FREE_LIST_PERF_EN adds a saturating stall_cycles counter output.
module free_list
  import free_list_pkg::*;
#(
  parameter int PR_NUM = FL_PR_NUM,
  parameter int AR_NUM = FL_AR_NUM,
  parameter int PR_W   = FL_PR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_stage4,
  input  logic            inst0_alloc_en,
  input  logic            inst1_alloc_en,
  input  logic            inst2_alloc_en,
  input  logic            inst3_alloc_en,
  output logic [PR_W-1:0] inst0_dest_PR,
  output logic [PR_W-1:0] inst1_dest_PR,
  output logic [PR_W-1:0] inst2_dest_PR,
  output logic [PR_W-1:0] inst3_dest_PR,
  output logic            alloc_stall,
  input  logic            retire0_en,
  input  logic            retire1_en,
  input  logic            retire2_en,
  input  logic            retire3_en,
  input  logic [PR_W-1:0] retire0_old_PR,
  input  logic [PR_W-1:0] retire1_old_PR,
  input  logic [PR_W-1:0] retire2_old_PR,
  input  logic [PR_W-1:0] retire3_old_PR,
  output logic [5:0]      free_cnt
`ifdef FREE_LIST_PERF_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  localparam int DEPTH = PR_NUM - AR_NUM;

  logic [PR_W-1:0]     entries_q [DEPTH];
  logic [PR_W-1:0]     entries_d [DEPTH];
  logic [FL_PTR_W-1:0] head_q, head_d, tail_q, tail_d, commit_q, commit_d;
  logic [FL_PTR_W-1:0] free_nxt;

  logic [3:0]      alloc_en, ret_en;
  logic [2:0]      a_off [4];
  logic [2:0]      r_off [4];
  logic [2:0]      a_cnt, r_cnt;
  logic [PR_W-1:0] ret_pr [4];
  logic [PR_W-1:0] dest   [4];

  assign alloc_en  = {inst3_alloc_en, inst2_alloc_en, inst1_alloc_en, inst0_alloc_en};
  assign ret_en    = {retire3_en, retire2_en, retire1_en, retire0_en};
  assign ret_pr[0] = retire0_old_PR;
  assign ret_pr[1] = retire1_old_PR;
  assign ret_pr[2] = retire2_old_PR;
  assign ret_pr[3] = retire3_old_PR;

  free_list_compact u_alloc_compact (
    .en(alloc_en), .off0(a_off[0]), .off1(a_off[1]), .off2(a_off[2]), .off3(a_off[3]), .cnt(a_cnt)
  );

  free_list_compact u_retire_compact (
    .en(ret_en), .off0(r_off[0]), .off1(r_off[1]), .off2(r_off[2]), .off3(r_off[3]), .cnt(r_cnt)
  );

  assign free_cnt    = tail_q - head_q;
  assign alloc_stall = {3'b000, a_cnt} > free_cnt;

  always_comb begin
    for (int n = 0; n < FL_SLOTS; n++) begin
      dest[n] = entries_q[head_q[FL_IDX_W-1:0] + FL_IDX_W'(a_off[n])];
    end
  end

  assign inst0_dest_PR = dest[0];
  assign inst1_dest_PR = dest[1];
  assign inst2_dest_PR = dest[2];
  assign inst3_dest_PR = dest[3];

  // Frees land at tail and only become visible to dest reads after the edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_d[i] = entries_q[i];
    for (int n = 0; n < FL_SLOTS; n++) begin
      if (ret_en[n]) entries_d[tail_q[FL_IDX_W-1:0] + FL_IDX_W'(r_off[n])] = ret_pr[n];
    end
    tail_d   = tail_q + FL_PTR_W'(r_cnt);
    commit_d = commit_q + FL_PTR_W'(r_cnt);
    if (flush_stage4)     head_d = commit_d;
    else if (!alloc_stall) head_d = head_q + FL_PTR_W'(a_cnt);
    else                  head_d = head_q;
    free_nxt = tail_d - head_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= PR_W'(AR_NUM + i);
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= FL_PTR_W'(DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
    end
  end

  // Returning more registers than the list can hold is an illegal input.
  always_ff @(posedge clk) begin
    if (!rst) assert (free_nxt <= FL_PTR_W'(DEPTH));
  end

`ifdef FREE_LIST_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (alloc_stall && !flush_stage4 && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PR_NUM, default 64, number of physical registers.
REQ-002 SHALL have parameter AR_NUM, default 32, number of architectural registers; list depth = PR_NUM-AR_NUM = 32.
REQ-003 SHALL have parameter PR_W, default 6, physical-register index width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_stage4  in  1  pipeline flush from commit.
REQ-007 SHALL have ports inst0_alloc_en..inst3_alloc_en  in  1 each  rename slot N needs a destination PR.
REQ-008 SHALL have ports inst0_dest_PR..inst3_dest_PR  out  PR_W each  PR allocated to slot N; feeds rename map and PR_status clear port.
REQ-009 SHALL have port alloc_stall  out  1  requested allocations exceed free entries.
REQ-010 SHALL have ports retire0_en..retire3_en  in  1 each  retiring instruction N had a destination.
REQ-011 SHALL have ports retire0_old_PR..retire3_old_PR  in  PR_W each  previous mapping to return to the list.
REQ-012 SHALL have port free_cnt  out  6  free entries, 0..32.

Function
REQ-013 SHALL hold PR indices in a 32-entry circular buffer with head, tail and commit_head pointers, each 6 bits (5-bit index plus wrap bit).
REQ-014 SHALL compact allocation: slot N reads entry head + (count of alloc_en among slots 0..N-1); dest_PR combinational from current state.
REQ-015 SHALL assert alloc_stall when popcount(alloc_en) > free_cnt; combinational.
REQ-016 SHALL allocate all-or-nothing: head advances by popcount(alloc_en) only when !alloc_stall && !flush_stage4; a stalled cycle pops nothing.
REQ-017 SHALL drive dest_PR with the head-relative value when alloc_en is low or stalled; consumers ignore it.
REQ-018 SHALL compact frees: enabled retire slots write old_PR at tail, tail+1, ... in slot order; tail advances by popcount(retire_en).
REQ-019 SHALL advance commit_head by popcount(retire_en) every cycle, including flush cycles.
REQ-020 SHALL make freed entries allocatable no earlier than the next cycle; no same-cycle bypass.
REQ-021 SHALL compute free_cnt = tail - head (6-bit modular) from registered pointers.
REQ-022 SHALL on flush_stage4 set head to the updated commit_head and apply that cycle's frees, so free_cnt = 32 next cycle.
REQ-023 SHALL wrap all pointers modulo 64, index bits modulo 32.
REQ-024 SHALL treat free count exceeding 32 (over-free) as an illegal input; behaviour undefined, flagged by assertion.

Reset
REQ-025 SHALL on rst load entry i with 32+i (i=0..31), head=0, commit_head=0, tail=32 (wrap set); free_cnt=32, alloc_stall=0 when no requests.
REQ-026 SHALL give rst priority over flush_stage4, alloc and retire; reset mid-operation discards all in-flight state.

Configuration
REQ-027 SHALL, with FREE_LIST_PERF_EN defined, add output stall_cycles (32 bits, reset 0, saturating) counting cycles with alloc_stall=1 and !flush_stage4.
REQ-028 SHALL, without FREE_LIST_PERF_EN, omit stall_cycles port and counter entirely.

Structure
REQ-029 SHALL take PR_NUM, AR_NUM, PR_W and the popcount/prefix-offset function from the shared core package.
REQ-030 SHALL be structured with one sub-module, free_list_compact, computing 4-slot prefix offsets and popcount; instanced twice (alloc, retire).

Verification
REQ-031 SHALL verify: reset, alloc_en=1111 -> dest_PR 32,33,34,35; next cycle free_cnt=28.
REQ-032 SHALL verify: alloc_en=1010 -> inst1_dest_PR=32, inst3_dest_PR=33; free_cnt 32->30.
REQ-033 SHALL verify: drain to free_cnt=2, alloc_en=0111 -> alloc_stall=1, head unchanged, free_cnt stays 2.
REQ-034 SHALL verify: free_cnt=0, retire0_en=1 old_PR=5 with alloc_en=0001 -> stall that cycle; next cycle inst0_dest_PR=5.
REQ-035 SHALL verify: allocate 12, retire 4 (old PR 0..3), flush_stage4 same cycle -> free_cnt=32; next allocation returns PR 36 (first entry after the 4 committed pops).
REQ-036 SHALL verify: 40 cycles of alloc 4 / retire 4 -> pointers wrap, no duplicate PR among outstanding allocations (scoreboard).
